// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column psum lanes that drain as a full row once every lane holds data
module ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*psum_bw-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [col*psum_bw-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   localparam int AW = $clog2(depth);

   logic [psum_bw-1:0]     mem_q [col][depth];
   logic [AW:0]            wr_ptr_q [col];
   logic [AW:0]            wr_ptr_d [col];
   logic [AW:0]            rd_ptr_q [col];
   logic [AW:0]            rd_ptr_d [col];
   logic [col*psum_bw-1:0] out_q, out_d;
   logic                   overflow_q, overflow_d;
   logic [col-1:0]         empty, full, push_ok;
   logic                   pop;

   // Pointers carry one extra MSB so a full lane is distinguishable from an empty one.
   always_comb begin
      empty = '0;
      full  = '0;
      for (int i = 0; i < col; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                    (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      end
   end

   assign o_valid    = ~|empty;
   assign o_full     = |full;
   assign o_ready    = ~o_full;
   assign o_overflow = overflow_q;
   assign out        = out_q;
   assign pop        = rd & o_valid;

   // A push into a full lane still lands when the same edge pops a row and frees the slot.
   always_comb begin
      push_ok    = wr & (~full | {col{pop}});
      overflow_d = overflow_q | (|(wr & full & ~{col{pop}}));
      out_d      = out_q;
      for (int i = 0; i < col; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push_ok[i]};
         rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop};
         if (pop) begin
            out_d[i*psum_bw +: psum_bw] = mem_q[i][rd_ptr_q[i][AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < col; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         out_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < col; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         out_q      <= out_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; stale entries are never visible because the pointers are.
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (push_ok[i]) begin
            mem_q[i][wr_ptr_q[i][AW-1:0]] <= in[i*psum_bw +: psum_bw];
         end
      end
   end

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - directed bench for ofifo with immediate-assertion checks
module tb_ofifo;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] din;
   logic [7:0]   wr;
   logic         rd;
   logic [127:0] dout;
   logic         o_valid, o_full, o_ready, o_overflow;

   int checks = 0;
   int errors = 0;

   logic [127:0] expv;
   logic [127:0] held;
   logic [127:0] ref_q [$];
   logic [127:0] row;
   logic         valid_ok, full_ok;

   ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (din),
      .wr        (wr),
      .rd        (rd),
      .out       (dout),
      .o_valid   (o_valid),
      .o_full    (o_full),
      .o_ready   (o_ready),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] fill_row(input int n);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) r[c*16 +: 16] = {c[3:0], n[11:0]};
      return r;
   endfunction

   initial begin
      reset = 1'b1;
      din   = '0;
      wr    = '0;
      rd    = 1'b0;
      #1;
      chk("reset_out", dout, '0);
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_ready", o_ready, 1'b1);
      chk("reset_full", o_full, 1'b0);
      chk("reset_ovf", o_overflow, 1'b0);
      #22 reset = 1'b0;
      tick();

      // skewed fill: one lane per cycle
      expv = '0;
      for (int c = 0; c < 8; c++) expv[c*16 +: 16] = 16'h0A00 + 16'(c);
      for (int c = 0; c < 8; c++) begin
         wr  = 8'(1 << c);
         din = expv;
         tick();
         chk($sformatf("skew_valid_c%0d", c), o_valid, (c == 7) ? 1'b1 : 1'b0);
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("skew_out", dout, expv);
      chk("skew_valid_after_pop", o_valid, 1'b0);

      // pop while empty
      rd = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("empty_pop_out", dout, expv);
         chk("empty_pop_valid", o_valid, 1'b0);
      end
      rd = 1'b0;

      // fill 64 deep, overflow, drain in order
      for (int n = 0; n < 64; n++) begin
         wr  = 8'hFF;
         din = fill_row(n);
         tick();
         if (n == 62) chk("fill_full_at_63", o_full, 1'b0);
      end
      chk("fill_full", o_full, 1'b1);
      chk("fill_ready", o_ready, 1'b0);
      chk("fill_ovf_before", o_overflow, 1'b0);
      din = {8{16'hDEAD}};
      tick();
      wr = '0;
      chk("fill_ovf_after", o_overflow, 1'b1);
      rd = 1'b1;
      for (int n = 0; n < 64; n++) begin
         tick();
         chk($sformatf("drain_row%0d", n), dout, fill_row(n));
         if (n == 0) chk("drain_full_clear", o_full, 1'b0);
      end
      rd = 1'b0;
      chk("drain_valid_end", o_valid, 1'b0);
      chk("drain_ovf_sticky", o_overflow, 1'b1);

      // async reset with lanes partially filled
      for (int n = 0; n < 10; n++) begin
         wr  = 8'hFF;
         din = fill_row(100 + n);
         tick();
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("pre_reset_out", dout, fill_row(100));
      reset = 1'b1;
      #1;
      chk("mid_reset_out", dout, '0);
      chk("mid_reset_valid", o_valid, 1'b0);
      chk("mid_reset_ready", o_ready, 1'b1);
      chk("mid_reset_ovf", o_overflow, 1'b0);
      #2 reset = 1'b0;
      tick();
      chk("post_reset_valid", o_valid, 1'b0);

      // lane 3 full with simultaneous push and pop
      for (int n = 0; n < 64; n++) begin
         wr  = 8'hFF;
         din = fill_row(n);
         tick();
      end
      wr  = 8'h08;
      din = {8{16'hBEEF}};
      rd  = 1'b1;
      tick();
      wr = '0;
      chk("pushpop_out", dout, fill_row(0));
      chk("pushpop_ovf", o_overflow, 1'b0);
      chk("pushpop_lane3_full", o_full, 1'b1);
      for (int n = 1; n < 64; n++) tick();
      rd = 1'b0;
      chk("pushpop_last_row", dout, fill_row(63));
      chk("pushpop_valid_end", o_valid, 1'b0);
      wr  = 8'hF7;
      din = {8{16'h1111}};
      tick();
      wr = '0;
      chk("pushpop_lane3_valid", o_valid, 1'b1);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      expv = {8{16'h1111}};
      expv[3*16 +: 16] = 16'hBEEF;
      chk("pushpop_lane3_data", dout, expv);

      // streaming push+pop every cycle
      for (int c = 0; c < 8; c++) row[c*16 +: 16] = 16'($urandom);
      wr  = 8'hFF;
      din = row;
      ref_q.push_back(row);
      tick();
      valid_ok = 1'b1;
      full_ok  = 1'b1;
      rd = 1'b1;
      for (int k = 0; k < 200; k++) begin
         for (int c = 0; c < 8; c++) row[c*16 +: 16] = 16'($urandom);
         din = row;
         ref_q.push_back(row);
         tick();
         held = ref_q.pop_front();
         chk($sformatf("stream_out%0d", k), dout, held);
         if (o_valid !== 1'b1) valid_ok = 1'b0;
         if (o_full !== 1'b0) full_ok = 1'b0;
      end
      wr = '0;
      rd = 1'b0;
      chk("stream_valid_never_dropped", valid_ok, 1'b1);
      chk("stream_full_never_set", full_ok, 1'b1);
      chk("stream_ovf", o_overflow, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
